// File: rtl/stack_ctrl.sv
// stack_ctrl: operand-stack sequencer for the stack-machine CPU.
//
// Top-of-stack lives in a register (tos). The DEPTH-1 entries under it live in a
// synchronous-read RAM, packed at ram[0..count-2], with ram[count-2] being the entry
// directly under TOS. A pop with count>=2 starts a RAM read and spends one REFILL
// cycle (ready=0) loading the new TOS from the read data.
//
// Optional feature: define STACK_ZERO_EN to enable the combinational zero flag
// (TOS==0 with a non-empty stack). Without it the zero port is tied low.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   push, pop, din  operation strobes and push data, honoured only while ready=1
//   dout            current TOS (0 when empty)
//   ready           1 when the sequencer accepts operations (IDLE)
//   count           number of valid entries, 0..DEPTH
//   empty, full     count==0, count==DEPTH
//   overflow        sticky: push while full (without pop)
//   underflow       sticky: pop while empty
//   zero            TOS==0 and stack non-empty (only with STACK_ZERO_EN)
module stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ready,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             zero
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] tos, tos_d;
    logic [CNT_W-1:0] count_d;
    logic             ovf_d, unf_d;
    logic             ram_we, ram_re;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] ram [0:DEPTH-2];

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign ready = (state == IDLE);
    // tos is forced to 0 whenever the stack drains, so dout needs no extra masking.
    assign dout  = tos;

    // Old TOS goes to the slot just above the current RAM top; the read fetches
    // next-under-TOS, which becomes TOS once the pop has decremented count.
    assign wr_addr = AW'(count - CNT_W'(1));
    assign rd_addr = AW'(count - CNT_W'(2));

`ifdef STACK_ZERO_EN
    assign zero = (tos == '0) && !empty;
`else
    assign zero = 1'b0;
`endif

    always_comb begin
        state_d = state;
        tos_d   = tos;
        count_d = count;
        ovf_d   = overflow;
        unf_d   = underflow;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state)
            IDLE: begin
                if (push && pop) begin
                    // Replace TOS; on an empty stack this degrades to a push.
                    tos_d = din;
                    if (empty) begin
                        count_d = CNT_W'(1);
                        unf_d   = 1'b1;
                    end
                end else if (push) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_we  = !empty;
                        tos_d   = din;
                        count_d = count + CNT_W'(1);
                    end
                end else if (pop) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else if (count == CNT_W'(1)) begin
                        tos_d   = '0;
                        count_d = '0;
                    end else begin
                        ram_re  = 1'b1;
                        count_d = count - CNT_W'(1);
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                // Strobes are ignored here; the requester holds them until ready.
                tos_d   = rd_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tos       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_d;
            tos       <= tos_d;
            count     <= count_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
        end
    end

    // Storage array: no reset, every location is written before it is read.
    always_ff @(posedge clk) begin
        if (ram_we) ram[wr_addr] <= tos;
        if (ram_re) rd_data <= ram[rd_addr];
    end

endmodule
